siso_frame_ctrl: RTL
====================

# siso_frame_ctrl

Frame sequencer for the 4-stage serial-in/serial-out shift register. It accepts a parallel word over a valid/ready handshake and clears the register. It then drives the word onto the register's serial input one bit per clock, samples the serial output after the register's propagation delay, and returns the received word over a second valid/ready handshake. The block sits between a parallel producer/consumer and the shift register datapath, and owns that register's `clear` and `s_in` pins.

## Interface
- `WIDTH`, 4, bits per frame (≥1).
- `DEPTH`, 4, stage count of the attached shift register (≥1).

- `clk`  input  1  rising-edge clock.
- `clear_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  producer has a frame.
- `in_data`  input  WIDTH  frame to transmit; bit WIDTH-1 is sent first.
- `in_ready`  output  1  block can accept a frame.
- `sr_clear`  output  1  active-high clear to the shift register.
- `sr_s_in`  output  1  serial data to the shift register.
- `sr_s_out`  input  1  serial data from the shift register.
- `out_valid`  output  1  received frame available.
- `out_data`  output  WIDTH  received frame; the first bit received lands in bit WIDTH-1.
- `out_ready`  input  1  consumer accepts the frame.
- `busy`  output  1  high in any state other than IDLE.
- `err`  output  1  received frame ≠ sent frame (see Configuration).

## Operation
- FSM states: IDLE, FLUSH, SHIFT, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `in_data` into the tx shifter and go to FLUSH.
- FLUSH
  - Exactly 1 cycle with `sr_clear`=1 and `sr_s_in`=0.
  - Load the cycle counter with WIDTH+DEPTH-1, clear the rx shifter, then go to SHIFT.
- SHIFT
  - Lasts WIDTH+DEPTH cycles, indexed k=0…WIDTH+DEPTH-1.
  - For k<WIDTH, `sr_s_in` = tx bit WIDTH-1-k. For k≥WIDTH, `sr_s_in`=0.
  - For k≥DEPTH, sample `sr_s_out` at the end of cycle k and shift it into the rx shifter LSB-side.
  - After the last cycle, go to DONE.
- DONE
  - `out_valid`=1 and `out_data` is held stable.
  - On `out_valid`&`out_ready`, go to IDLE.
- `in_ready`=1 only in IDLE. `in_valid` outside IDLE is ignored.
- Attached-register contract: the value on `sr_s_in` in cycle i is visible on `sr_s_out` in cycle i+DEPTH.
- The counter width is $clog2(WIDTH+DEPTH); it counts down and never wraps.

## Timing
- Reset values:
  - `in_ready`=1 and `busy`=0.
  - `sr_clear`=0 and `sr_s_in`=0.
  - `out_valid`=0, `out_data`=0, `err`=0.
  - State is IDLE and the counter is 0.
- All outputs except `in_ready` and `busy` are registered. `in_ready` and `busy` decode the state register directly.
- Latency: `out_valid` rises WIDTH+DEPTH+1 cycles after the input-accept edge.
- Minimum frame period is WIDTH+DEPTH+3 cycles: FLUSH + SHIFT + DONE + IDLE.
- `out_valid` stays high until accepted. Backpressure stalls DONE indefinitely and holds `out_data` and `err` stable.
- Reset mid-frame: `clear_n`=0 in any state returns to reset values on the next edge. The partial frame is discarded and `sr_clear` is not asserted.
- `in_valid` arriving in the same cycle that DONE is accepted is not taken. It is taken in the following IDLE cycle.

## Configuration
- `SISO_CHECK_EN` defined:
  - A copy of the sent word is kept.
  - On entry to DONE, `err` is set to (rx word ≠ sent word) and held until the DONE handshake. `err` clears on leaving DONE.
- `SISO_CHECK_EN` undefined:
  - The copy register and comparator are removed.
  - `err` is tied to 0.
  - All other behaviour is identical.

## Structure
- Package `siso_ctrl_pkg` holds:
  - the state enum type `siso_state_t` (IDLE, FLUSH, SHIFT, DONE);
  - the default-width constants.
- One sub-module: `siso_cycle_counter`, a loadable down-counter with load, enable and zero flag.
- The FSM and the tx/rx shifters stay in `siso_frame_ctrl`.
- Bench instantiates this block with a 4-stage SISO register (DEPTH=4) on `sr_*`.

## Test plan
- Single frame: `in_data`=4'b1001 accepted.
  - `sr_clear` is pulsed 1 cycle.
  - `sr_s_in` reads 1,0,0,1 over SHIFT cycles 0–3.
  - `out_valid` rises 9 cycles after accept with `out_data`=4'b1001 and `err`=0.
- Backpressure: `out_ready`=0 for 5 cycles in DONE.
  - `out_valid` stays 1 and `out_data` is stable.
  - `in_ready`=0 throughout.
  - The handshake returns the block to IDLE.
- Back-to-back: 4'b1010 then 4'b0111 with `in_valid` held high and `out_ready`=1.
  - Both frames return correctly.
  - Accept edges are 11 cycles apart.
- Ignored input: pulse `in_valid` with 4'b1111 during SHIFT of 4'b0001.
  - The output is 4'b0001.
  - No second frame starts.
- Reset mid-SHIFT: `clear_n`=0 at SHIFT cycle 3.
  - The next edge gives IDLE, `out_valid`=0, `sr_s_in`=0, `busy`=0.
  - A new frame of 4'b0110 then completes correctly.
- `SISO_CHECK_EN` defined, with the bench inverting `sr_s_out` and sending 4'b1100.
  - `out_data`=4'b0011 and `err`=1 in DONE.
  - `err`=0 after the handshake.

Source files
------------

// File: rtl/siso_ctrl_pkg.sv
// Shared types and default sizes for the SISO frame sequencer.
package siso_ctrl_pkg;

  localparam int SISO_WIDTH = 4;
  localparam int SISO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } siso_state_t;

  // Counter must hold WIDTH+DEPTH-1, the first SHIFT index counted down from.
  function automatic int siso_cnt_w(input int width, input int depth);
    return $clog2(width + depth);
  endfunction

endpackage

// File: rtl/siso_cycle_counter.sv
// Loadable saturating down-counter used to time the SHIFT phase of a frame.
module siso_cycle_counter
  import siso_ctrl_pkg::*;
#(
  parameter int CW = siso_cnt_w(SISO_WIDTH, SISO_DEPTH)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_r;

  // Load has priority; counting stops at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/siso_frame_ctrl.sv
// Frame sequencer for an external DEPTH-stage SISO shift register.
// Optional self-check of the returned word is enabled by defining SISO_CHECK_EN.
module siso_frame_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = SISO_WIDTH,
  parameter int DEPTH = SISO_DEPTH
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sr_clear,
  output logic             sr_s_in,
  input  logic             sr_s_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  localparam int            CW         = siso_cnt_w(WIDTH, DEPTH);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(WIDTH);

  siso_state_t      state_r;
  siso_state_t      state_s;
  logic [CW-1:0]    cnt_s;
  logic             cnt_zero_s;
  logic             cnt_load_s;
  logic             cnt_en_s;
  logic [WIDTH-1:0] tx_r;
  logic [WIDTH-1:0] rx_r;
  logic [WIDTH-1:0] rx_shift_s;
  logic [WIDTH-1:0] out_data_r;
  logic             sr_clear_r;
  logic             sr_s_in_r;
  logic             out_valid_r;
  logic             sr_clear_nxt_s;
  logic             sr_s_in_nxt_s;
  logic             out_valid_nxt_s;
  logic             in_ready_s;
  logic             busy_s;
  logic             accept_s;
  logic             sample_s;
  logic             done_entry_s;

  // SHIFT is indexed k = CNT_LOAD - cnt; samples are taken once k >= DEPTH.
  siso_cycle_counter #(
    .CW (CW)
  ) u_cycle_counter (
    .clk      (clk),
    .clear_n  (clear_n),
    .load     (cnt_load_s),
    .load_val (CNT_LOAD),
    .en       (cnt_en_s),
    .cnt      (cnt_s),
    .zero     (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = FLUSH;
        else          state_s = IDLE;
      end
      FLUSH: state_s = SHIFT;
      SHIFT: begin
        if (cnt_zero_s) state_s = DONE;
        else            state_s = SHIFT;
      end
      DONE: begin
        if (out_valid_r && out_ready) state_s = IDLE;
        else                          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode: handshake flags from the current state, D-inputs of the output flops from the next state.
  always_comb begin
    in_ready_s      = (state_r == IDLE);
    busy_s          = (state_r != IDLE);
    accept_s        = in_ready_s && in_valid;
    cnt_load_s      = (state_r == FLUSH);
    cnt_en_s        = (state_r == SHIFT);
    sample_s        = (state_r == SHIFT) && (cnt_s < CNT_SAMPLE);
    done_entry_s    = (state_r == SHIFT) && (state_s == DONE);
    sr_clear_nxt_s  = (state_s == FLUSH);
    sr_s_in_nxt_s   = (state_s == SHIFT) ? tx_r[WIDTH-1] : 1'b0;
    out_valid_nxt_s = (state_s == DONE);
    rx_shift_s      = WIDTH'({rx_r, sr_s_out});
  end

  // Output flops and tx/rx shifters; tx fills with zeros, which become the flush-out bits.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sr_clear_r  <= 1'b0;
      sr_s_in_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      tx_r        <= {WIDTH{1'b0}};
      rx_r        <= {WIDTH{1'b0}};
    end else begin
      sr_clear_r  <= sr_clear_nxt_s;
      sr_s_in_r   <= sr_s_in_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      if (accept_s) begin
        tx_r <= in_data;
      end else if (state_s == SHIFT) begin
        tx_r <= tx_r << 1'b1;
      end else begin
        tx_r <= tx_r;
      end
      if (cnt_load_s) begin
        rx_r <= {WIDTH{1'b0}};
      end else if (sample_s) begin
        rx_r <= rx_shift_s;
      end else begin
        rx_r <= rx_r;
      end
      if (done_entry_s) begin
        out_data_r <= rx_shift_s;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

`ifdef SISO_CHECK_EN
  logic [WIDTH-1:0] sent_r;
  logic             err_r;

  // The tx shifter is consumed during SHIFT, so the compare uses a separate copy.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sent_r <= {WIDTH{1'b0}};
      err_r  <= 1'b0;
    end else begin
      if (accept_s) sent_r <= in_data;
      else          sent_r <= sent_r;
      if (done_entry_s) begin
        err_r <= (rx_shift_s != sent_r);
      end else if ((state_r == DONE) && (state_s == IDLE)) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = in_ready_s;
  assign busy      = busy_s;
  assign sr_clear  = sr_clear_r;
  assign sr_s_in   = sr_s_in_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule
